// File: rtl/enc_rr_arbiter.sv
// enc_rr_arbiter: round-robin arbiter granting an encoded resource to one of eight requesters
module enc_rr_arbiter #(
  parameter int HOLD_MAX = 16,
  parameter int CNTW     = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [7:0]      req_in,
  input  logic            EN_release,
  output logic [7:0]      grant_out,
  output logic [2:0]      grant_idx,
  output logic            RDY_grant,
  output logic            timeout_out,
  output logic [CNTW-1:0] grant_count
);
  typedef enum logic {IDLE, GRANTED} state_t;
  state_t state, state_d;
  logic [2:0] ptr, winner, off;
  logic [7:0] rot, hold_cnt;
  logic done, forced;
  // rotate requests so ptr sits at bit 0, pick the lowest set bit, rotate back
  always_comb begin
    rot = 8'({req_in, req_in} >> ptr);
    off = 3'd0;
    for (int i = 7; i >= 0; i--) if (rot[i]) off = 3'(i);
    winner = ptr + off;
  end
  // end-of-grant detection and next state; release and requester drop outrank timeout
  always_comb begin
    done    = EN_release || !req_in[grant_idx] || hold_cnt == 8'(HOLD_MAX - 1);
    forced  = done && !EN_release && req_in[grant_idx];
    state_d = state == IDLE ? (|req_in ? GRANTED : IDLE) : (done ? IDLE : GRANTED);
  end
  // state register
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_d;
  end
  // registered grant outputs, rotation pointer, hold timer and grant counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr         <= 3'd0;
      hold_cnt    <= 8'd0;
      grant_out   <= 8'h00;
      grant_idx   <= 3'd0;
      timeout_out <= 1'b0;
      grant_count <= '0;
    end else begin
      timeout_out <= state == GRANTED && forced;
      if (state == IDLE && |req_in) begin
        grant_out   <= 8'd1 << winner;
        grant_idx   <= winner;
        hold_cnt    <= 8'd0;
        grant_count <= &grant_count ? grant_count : grant_count + CNTW'(1);
      end else if (state == GRANTED) begin
        if (done) begin
          ptr       <= grant_idx + 3'd1;
          grant_out <= 8'h00;
          grant_idx <= 3'd0;
          hold_cnt  <= 8'd0;
        end else begin
          hold_cnt  <= hold_cnt + 8'd1;
        end
      end
    end
  end
  assign RDY_grant = state == GRANTED;
endmodule

// File: tb/tb_enc_rr_arbiter.sv
// tb_enc_rr_arbiter: randomized and directed checks of enc_rr_arbiter against a behavioural model
module tb_enc_rr_arbiter;
  localparam int HOLD_MAX = 16;
  localparam int CNTW     = 4;
  localparam int SAT      = (1 << CNTW) - 1;

  logic            CLK = 1'b0;
  logic            RST;
  logic [7:0]      req_in;
  logic            EN_release;
  logic [7:0]      grant_out;
  logic [2:0]      grant_idx;
  logic            RDY_grant;
  logic            timeout_out;
  logic [CNTW-1:0] grant_count;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // model: granted flag, holder, next-priority requester, cycles held, grants issued, timeout flag
  bit m_g   = 1'b0;
  int m_idx = 0;
  int m_ptr = 0;
  int m_h   = 0;
  int m_cnt = 0;
  bit m_tmo = 1'b0;

  enc_rr_arbiter #(.HOLD_MAX(HOLD_MAX), .CNTW(CNTW)) dut (
    .CLK(CLK), .RST(RST), .req_in(req_in), .EN_release(EN_release),
    .grant_out(grant_out), .grant_idx(grant_idx), .RDY_grant(RDY_grant),
    .timeout_out(timeout_out), .grant_count(grant_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // model steps once per rising edge from the sampled inputs
  always @(posedge CLK) begin
    automatic bit g = m_g, t = 1'b0;
    automatic int idx = m_idx, p = m_ptr, h = m_h, c = m_cnt;
    if (RST) begin
      g = 1'b0; idx = 0; p = 0; h = 0; c = 0;
    end else if (!g) begin
      if (req_in != 8'h00) begin
        for (int k = 7; k >= 0; k--) if (req_in[(m_ptr + k) % 8]) idx = (m_ptr + k) % 8;
        g = 1'b1; h = 1; c = c + 1;
      end
    end else if (EN_release || !req_in[m_idx]) begin
      g = 1'b0; p = (m_idx + 1) % 8;
    end else if (m_h == HOLD_MAX) begin
      g = 1'b0; p = (m_idx + 1) % 8; t = 1'b1;
    end else begin
      h = h + 1;
    end
    m_g   <= g;
    m_idx <= idx;
    m_ptr <= p;
    m_h   <= h;
    m_cnt <= c;
    m_tmo <= t;
  end

  // every cycle after initial reset, compare all outputs against the model
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("mdl_grant_out", int'(grant_out), m_g ? (1 << m_idx) : 0);
      chk("mdl_grant_idx", int'(grant_idx), m_g ? m_idx : 0);
      chk("mdl_rdy", int'(RDY_grant), int'(m_g));
      chk("mdl_timeout", int'(timeout_out), int'(m_tmo));
      chk("mdl_count", int'(grant_count), m_cnt > SAT ? SAT : m_cnt);
    end
  end

  task automatic rst_pulse();
    RST = 1'b1; req_in = 8'h00; EN_release = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1; req_in = 8'h00; EN_release = 1'b0;
    repeat (2) @(negedge CLK);
    chk_en = 1'b1;
    chk("rst_grant_out", int'(grant_out), 0);
    chk("rst_count", int'(grant_count), 0);
    RST = 1'b0; req_in = 8'h20;
    @(negedge CLK);
    chk("t1_grant_out", int'(grant_out), 'h20);
    chk("t1_grant_idx", int'(grant_idx), 5);
    chk("t1_rdy", int'(RDY_grant), 1);
    chk("t1_count", int'(grant_count), 1);
    EN_release = 1'b1; req_in = 8'h00;
    @(negedge CLK);
    chk("t1_released", int'(RDY_grant), 0);
    EN_release = 1'b0;

    rst_pulse();
    req_in = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      @(negedge CLK);
      chk("rr_idx", int'(grant_idx), i % 8);
      chk("rr_rdy", int'(RDY_grant), 1);
      EN_release = 1'b1;
      @(negedge CLK);
      chk("rr_idle_gap", int'(RDY_grant), 0);
      EN_release = 1'b0;
    end

    rst_pulse();
    req_in = 8'h81;
    @(negedge CLK);
    chk("to_first_idx", int'(grant_idx), 0);
    repeat (15) @(negedge CLK);
    chk("to_last_held", int'(RDY_grant), 1);
    chk("to_no_early_pulse", int'(timeout_out), 0);
    @(negedge CLK);
    chk("to_dropped", int'(RDY_grant), 0);
    chk("to_pulse", int'(timeout_out), 1);
    @(negedge CLK);
    chk("to_next_idx", int'(grant_idx), 7);
    chk("to_pulse_end", int'(timeout_out), 0);
    EN_release = 1'b1;
    @(negedge CLK);
    EN_release = 1'b0;
    @(negedge CLK);
    chk("to_wrap_idx", int'(grant_idx), 0);

    rst_pulse();
    req_in = 8'h18;
    @(negedge CLK);
    chk("drop_idx", int'(grant_idx), 3);
    repeat (3) @(negedge CLK);
    req_in = 8'h11;
    @(negedge CLK);
    chk("drop_rdy", int'(RDY_grant), 0);
    chk("drop_no_timeout", int'(timeout_out), 0);
    @(negedge CLK);
    chk("drop_next_idx", int'(grant_idx), 4);

    rst_pulse();
    req_in = 8'h01;
    @(negedge CLK);
    repeat (15) @(negedge CLK);
    EN_release = 1'b1;
    @(negedge CLK);
    chk("relto_rdy", int'(RDY_grant), 0);
    chk("relto_no_timeout", int'(timeout_out), 0);
    EN_release = 1'b0;
    @(negedge CLK);
    chk("relto_regrant", int'(RDY_grant), 1);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("midrst_grant_out", int'(grant_out), 0);
    chk("midrst_rdy", int'(RDY_grant), 0);
    chk("midrst_count", int'(grant_count), 0);
    RST = 1'b0; req_in = 8'hFF;
    @(negedge CLK);
    chk("midrst_ptr0", int'(grant_idx), 0);

    rst_pulse();
    req_in = 8'h01;
    for (int i = 1; i <= 17; i++) begin
      @(negedge CLK);
      chk("sat_count", int'(grant_count), i > SAT ? SAT : i);
      EN_release = 1'b1;
      @(negedge CLK);
      EN_release = 1'b0;
    end

    for (int i = 0; i < 4000; i++) begin
      RST = $urandom_range(199) == 0;
      if ($urandom_range(19) == 0) req_in = 8'($urandom) & 8'($urandom);
      EN_release = $urandom_range(15) == 0;
      @(negedge CLK);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
